conv_feed_master: RTL

- Bus initiator that drives the 3x3 convolution accelerator's register port (addr/en/we/din/dout) on behalf of the CPU.
- On a start pulse it:
  - fetches 9 weights and N pixels from a word-addressed source memory,
  - programs the weights and clears the accelerator,
  - streams the pixels, reading the result register after each one,
  - writes each result word to a destination memory.
- Sits between the MMIO control block and the accelerator, replacing per-pixel CPU stores and loads.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_feed_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution feed master:
//   - accelerator register indices and weight count
//   - offset from the weight block to the first pixel in source memory
//   - FSM state encoding
// ----------------------------------------------------------------------------
package conv_pkg;

    // Accelerator register map
    localparam logic [3:0] ACC_PIX = 4'd0;   // pixel write
    localparam logic [3:0] ACC_RES = 4'd1;   // result read
    localparam logic [3:0] ACC_CLR = 4'd2;   // clear
    localparam logic [3:0] ACC_W0  = 4'd3;   // weight 0 (weights 0..8 at 3..11)
    localparam int         NUM_W   = 9;

    // Pixels follow the 9 weights in source memory
    localparam int         PIX_OFS = 9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_RD,
        S_W_WR,
        S_CLR,
        S_P_RD,
        S_P_WR,
        S_R_RD,
        S_R_WB,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_feed_master.sv
// ----------------------------------------------------------------------------
// conv_feed_master
// Bus initiator for the 3x3 convolution accelerator. On a start pulse it
// copies 9 weights from source memory into the accelerator, clears it, then
// for each of N pixels: reads the pixel, writes it to the accelerator, reads
// the result register and stores the result to destination memory.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          job control (abort wins over start)
//   src_base              address of weight 0; pixels begin at src_base+9
//   dst_base              address of result 0
//   num_pix               pixel count N (0 allowed: weights + clear only)
//   busy, done, res_cnt   job status; res_cnt holds after abort/completion
//   mem_ren/raddr/rdata   source read port, rdata valid 1 cycle after ren
//   mem_wen/waddr/wdata   destination write port
//   acc_en/we/addr/din    accelerator register port
//   acc_dout              accelerator read data, valid 1 cycle after a read
//
// All strobes, addresses and write data are pure decodes of the current state
// and registers, so a reset drives every output to 0 immediately. Abort only
// steers the next state: a strobe already decoded in the abort cycle (for
// example the R_WB write) completes and is counted.
// ----------------------------------------------------------------------------
module conv_feed_master
    import conv_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  num_pix,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  res_cnt,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              acc_en,
    output logic              acc_we,
    output logic [3:0]        acc_addr,
    output logic [DATA_W-1:0] acc_din,
    input  logic [DATA_W-1:0] acc_dout
);

    // k indexes both the weights (0..8) and the pixels (0..N-1)
    localparam int K_W = (CNT_W > 4) ? CNT_W : 4;

    state_t            state;
    logic [K_W-1:0]    k;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  n_q;
    logic [K_W-1:0]    k_last_pix;

    assign k_last_pix = K_W'(n_q) - K_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            k       <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            n_q     <= '0;
            res_cnt <= '0;
        end else begin
            // The R_WB write is decoded from state, so it lands even when
            // abort arrives in the same cycle; count it regardless.
            if (state == S_R_WB)
                res_cnt <= res_cnt + CNT_W'(1);

            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            src_q   <= src_base;
                            dst_q   <= dst_base;
                            n_q     <= num_pix;
                            k       <= '0;
                            res_cnt <= '0;
                            state   <= S_W_RD;
                        end
                    end
                    S_W_RD: state <= S_W_WR;
                    S_W_WR: begin
                        if (k == K_W'(NUM_W - 1)) begin
                            k     <= '0;
                            state <= S_CLR;
                        end else begin
                            k     <= k + K_W'(1);
                            state <= S_W_RD;
                        end
                    end
                    S_CLR:  state <= (n_q == '0) ? S_DONE : S_P_RD;
                    S_P_RD: state <= S_P_WR;
                    S_P_WR: state <= S_R_RD;
                    S_R_RD: state <= S_R_WB;
                    S_R_WB: begin
                        if (k == k_last_pix) begin
                            state <= S_DONE;
                        end else begin
                            k     <= k + K_W'(1);
                            state <= S_P_RD;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        mem_ren   = 1'b0;
        mem_raddr = '0;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        acc_en    = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = '0;
        acc_din   = '0;
        case (state)
            S_W_RD: begin
                mem_ren   = 1'b1;
                mem_raddr = src_q + ADDR_W'(k);
            end
            S_W_WR: begin
                acc_en   = 1'b1;
                acc_we   = 1'b1;
                acc_addr = ACC_W0 + k[3:0];
                acc_din  = mem_rdata;
            end
            S_CLR: begin
                acc_en   = 1'b1;
                acc_we   = 1'b1;
                acc_addr = ACC_CLR;
            end
            S_P_RD: begin
                mem_ren   = 1'b1;
                mem_raddr = src_q + ADDR_W'(PIX_OFS) + ADDR_W'(k);
            end
            S_P_WR: begin
                acc_en   = 1'b1;
                acc_we   = 1'b1;
                acc_addr = ACC_PIX;
                acc_din  = mem_rdata;
            end
            S_R_RD: begin
                acc_en   = 1'b1;
                acc_addr = ACC_RES;
            end
            S_R_WB: begin
                mem_wen   = 1'b1;
                mem_waddr = dst_q + ADDR_W'(k);
                mem_wdata = acc_dout;
            end
            default: ;
        endcase
    end

endmodule
